// File: rtl/kernel_kcore_v2h_hls_deadlock_pkg.sv
// kernel_kcore_v2h_hls_deadlock_pkg: shared FSM states, defaults and index-width helper for the deadlock report controller.
package kernel_kcore_v2h_hls_deadlock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ORIGIN,
        ST_TRACE,
        ST_REPORT,
        ST_HOLD
    } state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    function automatic int idw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/kernel_kcore_v2h_hls_rr_pick.sv
// kernel_kcore_v2h_hls_rr_pick: cyclic priority encoder, first set request at or above ptr.
module kernel_kcore_v2h_hls_rr_pick
    import kernel_kcore_v2h_hls_deadlock_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] idx
);

    logic [IDW-1:0] j;

    // Scan from the farthest offset down so the closest request to ptr is written last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        j      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = IDW'((int'(ptr) + i) % N);
            if (req[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end

endmodule

// File: rtl/kernel_kcore_v2h_hls_deadlock_report_ctrl.sv
// kernel_kcore_v2h_hls_deadlock_report_ctrl: arbitrates deadlock detect units, times token circulation
// and serialises the recorded dependency cycle to a valid/ready report sink.
module kernel_kcore_v2h_hls_deadlock_report_ctrl
    import kernel_kcore_v2h_hls_deadlock_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int IDW = idw(PROC_NUM)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                dl_detect_global,
    output logic [PROC_NUM-1:0] cycle_vec,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [IDW-1:0]      rpt_proc_id,
    output logic                rpt_last,
    input  logic                ack_clear,
    output logic                busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_e              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      winner_q, winner_d;
    logic [IDW-1:0]      rpt_idx_q, rpt_idx_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [PROC_NUM-1:0] cycle_vec_q, cycle_vec_d;
    logic [PROC_NUM-1:0] origin_q, origin_d;

    logic [PROC_NUM-1:0] arb_onehot, rpt_req, rpt_onehot, cur_onehot;
    logic [IDW-1:0]      arb_idx, rpt_ptr, rpt_idx;

    kernel_kcore_v2h_hls_rr_pick #(.N(PROC_NUM)) u_arb (
        .req    (dl_in_vec),
        .ptr    (rr_ptr_q),
        .onehot (arb_onehot),
        .idx    (arb_idx)
    );

    // In TRACE this finds the first beat of the final cycle set; in REPORT the next beat after the current one.
    assign rpt_req = cycle_vec_q | ((state_q == ST_TRACE) ? dl_in_vec : '0);
    assign rpt_ptr = (state_q != ST_REPORT) ? '0 :
                     (rpt_idx_q == IDW'(PROC_NUM - 1)) ? '0 : rpt_idx_q + IDW'(1);

    kernel_kcore_v2h_hls_rr_pick #(.N(PROC_NUM)) u_rpt (
        .req    (rpt_req),
        .ptr    (rpt_ptr),
        .onehot (rpt_onehot),
        .idx    (rpt_idx)
    );

    // The next set bit wrapping to or below the current one means this beat is the highest.
    assign cur_onehot       = PROC_NUM'(1) << rpt_idx_q;
    assign rpt_valid        = (state_q == ST_REPORT);
    assign rpt_last         = rpt_valid && (rpt_onehot <= cur_onehot);
    assign rpt_proc_id      = rpt_valid ? rpt_idx_q : '0;
    assign busy             = (state_q != ST_IDLE);
    assign dl_detect_global = busy;
    assign origin_vec       = origin_q;
    assign cycle_vec        = cycle_vec_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        winner_d    = winner_q;
        rpt_idx_d   = rpt_idx_q;
        timer_d     = timer_q;
        cycle_vec_d = cycle_vec_q;
        origin_d    = '0;
        token_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|dl_in_vec) begin
                    winner_d    = arb_idx;
                    rr_ptr_d    = (arb_idx == IDW'(PROC_NUM - 1)) ? '0 : arb_idx + IDW'(1);
                    cycle_vec_d = arb_onehot;
                    origin_d    = arb_onehot;
                    state_d     = ST_ORIGIN;
                end
            end
            ST_ORIGIN: begin
                timer_d = '0;
                state_d = ST_TRACE;
            end
            ST_TRACE: begin
                cycle_vec_d = cycle_vec_q | dl_in_vec;
                timer_d     = timer_q + TW'(1);
                if (dl_in_vec[winner_q]) begin
                    token_clear = 1'b1;
                    rpt_idx_d   = rpt_idx;
                    state_d     = ST_REPORT;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    token_clear = 1'b1;
                    cycle_vec_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            ST_REPORT: begin
                if (rpt_ready) begin
                    if (rpt_last) state_d = ST_HOLD;
                    else rpt_idx_d = rpt_idx;
                end
            end
            ST_HOLD: begin
                if (ack_clear) begin
                    cycle_vec_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            rpt_idx_q   <= '0;
            timer_q     <= '0;
            cycle_vec_q <= '0;
            origin_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            winner_q    <= winner_d;
            rpt_idx_q   <= rpt_idx_d;
            timer_q     <= timer_d;
            cycle_vec_q <= cycle_vec_d;
            origin_q    <= origin_d;
        end
    end

endmodule
